// File: rtl/sga_pkg.sv
// Shared definitions for the snake game core: FSM state codes, direction
// codes, grid geometry, cell-index helpers and the 7-segment hex table.
package sga_pkg;

    localparam int GRID  = 6;
    localparam int CELLS = GRID * GRID;

    typedef logic [5:0] cell_t;   // cell index y*GRID+x
    typedef logic [1:0] dir_t;    // movement direction code

    // Main FSM state codes (shown on the debug 7-segment digit)
    localparam logic [3:0] ST_IDLE  = 4'h0;
    localparam logic [3:0] ST_INIT  = 4'h1;
    localparam logic [3:0] ST_PLACE = 4'h2;
    localparam logic [3:0] ST_WAIT  = 4'h3;
    localparam logic [3:0] ST_MOVE  = 4'h4;
    localparam logic [3:0] ST_WIN   = 4'hA;
    localparam logic [3:0] ST_LOST  = 4'hE;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_LEFT  = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    function automatic logic [2:0] cell_x(input cell_t c);
        return 3'(c % 6'(GRID));
    endfunction

    function automatic logic [2:0] cell_y(input cell_t c);
        return 3'(c / 6'(GRID));
    endfunction

    function automatic cell_t cell_of(input logic [2:0] x, input logic [2:0] y);
        return {3'b000, y} * 6'(GRID) + {3'b000, x};
    endfunction

    // One step of the x^6+x^5+1 Fibonacci LFSR
    function automatic cell_t lfsr_step(input cell_t v);
        return {v[4:0], v[5] ^ v[4]};
    endfunction

    // Hex digit to active-low segments, bit order gfedcba
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] on;
        case (h)
            4'h0: on = 7'h3F;
            4'h1: on = 7'h06;
            4'h2: on = 7'h5B;
            4'h3: on = 7'h4F;
            4'h4: on = 7'h66;
            4'h5: on = 7'h6D;
            4'h6: on = 7'h7D;
            4'h7: on = 7'h07;
            4'h8: on = 7'h7F;
            4'h9: on = 7'h6F;
            4'hA: on = 7'h77;
            4'hB: on = 7'h7C;
            4'hC: on = 7'h39;
            4'hD: on = 7'h5E;
            4'hE: on = 7'h79;
            default: on = 7'h71;
        endcase
        return ~on;
    endfunction

endpackage

// File: rtl/sga_hex7seg.sv
// 4-bit code to active-low 7-segment pattern (gfedcba).
module sga_hex7seg
    import sga_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // Pure table lookup
    always_comb seg_o = hex_to_seg(code_i);

endmodule

// File: rtl/sga.sv
// Snake game core for a 6x6 LED matrix: snake body, direction, apple
// placement, game FSM, LED frame and debug taps.
module sga
    import sga_pkg::*;
#(
    parameter int          MOVE_PERIOD = 25_000_000,
    parameter int          MAX_SIZE    = 15,
    parameter logic [5:0]  LFSR_SEED   = 6'h2D
) (
    input  logic        clock,
    input  logic        restart,
    input  logic [3:0]  buttons,
    input  logic        start,
    output logic [35:0] leds,
    output logic [6:0]  db_state,
    output logic [6:0]  db_state2,
    output logic [2:0]  db_appleX,
    output logic [2:0]  db_appleY,
    output logic [2:0]  db_headX,
    output logic [2:0]  db_headY,
    output logic [3:0]  db_size
);

    localparam int               TICK_W     = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MOVE_PERIOD - 1);
    localparam logic [3:0]       SIZE_WIN   = 4'(MAX_SIZE);
    localparam cell_t            START_CELL = cell_of(3'd2, 3'd2);

    logic [3:0]        state_q, state_d;
    logic [3:0]        size_q, size_d;
    dir_t              dir_q, dir_d, pend_q, pend_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    cell_t             lfsr_q, lfsr_d;
    cell_t             apple_q, apple_d;
    cell_t             body_q [MAX_SIZE];
    logic              body_shift, body_init;

    logic [2:0]        head_x, head_y;
    cell_t             next_cell;
    logic              off_grid, eat;
    logic [MAX_SIZE-1:0] seg_active, seg_hit, seg_on_cand;
    logic              btn_any, btn_ok;
    dir_t              btn_dir;

    // Candidate head cell for the pending direction and wall detection
    always_comb begin
        head_x    = cell_x(body_q[0]);
        head_y    = cell_y(body_q[0]);
        off_grid  = 1'b0;
        next_cell = body_q[0];
        case (pend_q)
            DIR_UP:    begin off_grid = (head_y == 3'd0); next_cell = body_q[0] - 6'd6; end
            DIR_LEFT:  begin off_grid = (head_x == 3'd0); next_cell = body_q[0] - 6'd1; end
            DIR_DOWN:  begin off_grid = (head_y == 3'd5); next_cell = body_q[0] + 6'd6; end
            default:   begin off_grid = (head_x == 3'd5); next_cell = body_q[0] + 6'd1; end
        endcase
        eat = (next_cell == apple_q);
    end

    // Per-segment occupancy: self-collision (tail may be vacated) and apple overlap
    for (genvar gi = 0; gi < MAX_SIZE; gi++) begin : g_seg
        assign seg_active[gi]  = (4'(gi) < size_q);
        assign seg_hit[gi]     = seg_active[gi] && (body_q[gi] == next_cell)
                                 && !(!eat && (4'(gi) == size_q - 4'd1));
        assign seg_on_cand[gi] = seg_active[gi] && (body_q[gi] == lfsr_q);
    end

    // Lowest-index pressed button wins; a U-turn is refused once the snake has a body
    always_comb begin
        btn_any = |buttons;
        if (buttons[0])      btn_dir = DIR_UP;
        else if (buttons[1]) btn_dir = DIR_LEFT;
        else if (buttons[2]) btn_dir = DIR_DOWN;
        else                 btn_dir = DIR_RIGHT;
        btn_ok = btn_any && !((size_q > 4'd1) && (btn_dir == (dir_q ^ 2'd2)));
    end

    // Game FSM next-state logic
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        tick_d     = tick_q;
        lfsr_d     = lfsr_q;
        apple_d    = apple_q;
        body_shift = 1'b0;
        body_init  = 1'b0;
        if ((state_q == ST_PLACE || state_q == ST_WAIT) && btn_ok)
            pend_d = btn_dir;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_INIT;
            ST_INIT: begin
                size_d    = 4'd1;
                body_init = 1'b1;
                dir_d     = DIR_RIGHT;
                pend_d    = DIR_RIGHT;
                tick_d    = '0;
                state_d   = ST_PLACE;
            end
            ST_PLACE: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (lfsr_q < 6'(CELLS) && !(|seg_on_cand)) begin
                    apple_d = lfsr_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    state_d = ST_MOVE;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_MOVE: begin
                dir_d = pend_q;
                if (off_grid || (|seg_hit)) begin
                    state_d = ST_LOST;
                end else begin
                    body_shift = 1'b1;
                    if (eat) begin
                        size_d  = size_q + 4'd1;
                        state_d = (size_q + 4'd1 == SIZE_WIN) ? ST_WIN : ST_PLACE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WIN, ST_LOST: if (start) state_d = ST_INIT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clock) begin
        if (restart) begin
            state_q <= ST_IDLE;
            size_q  <= 4'd0;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            tick_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            apple_q <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
            lfsr_q  <= lfsr_d;
            apple_q <= apple_d;
        end
    end

    // Body shift register: new head enters at index 0, everything moves down one
    always_ff @(posedge clock) begin
        if (restart) begin
            for (int i = 0; i < MAX_SIZE; i++) body_q[i] <= '0;
        end else if (body_init) begin
            body_q[0] <= START_CELL;
        end else if (body_shift) begin
            body_q[0] <= next_cell;
            for (int i = 1; i < MAX_SIZE; i++) body_q[i] <= body_q[i-1];
        end
    end

    // LED frame: active segments, plus the apple once it has been placed
    always_comb begin
        leds = '0;
        for (int i = 0; i < MAX_SIZE; i++)
            if (seg_active[i]) leds = leds | (36'd1 << body_q[i]);
        if (state_q == ST_WAIT || state_q == ST_MOVE || state_q == ST_WIN || state_q == ST_LOST)
            leds = leds | (36'd1 << apple_q);
        if (state_q == ST_IDLE)
            leds = '0;
    end

    assign db_appleX = cell_x(apple_q);
    assign db_appleY = cell_y(apple_q);
    assign db_headX  = head_x;
    assign db_headY  = head_y;
    assign db_size   = size_q;

    sga_hex7seg u_seg_state (.code_i(state_q),         .seg_o(db_state));
    sga_hex7seg u_seg_dir   (.code_i({2'b00, dir_q}),  .seg_o(db_state2));

endmodule

// File: tb/tb_sga.sv
// Bench for the snake core: a queue-based game model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sga;

    localparam int MP = 8;
    localparam int MS = 15;
    // Active-low gfedcba digits 0..F
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam int DX [4] = '{0, -1, 0, 1};
    localparam int DY [4] = '{-1, 0, 1, 0};

    logic        clock   = 1'b0;
    logic        restart = 1'b1;
    logic [3:0]  buttons = 4'd0;
    logic        start   = 1'b0;
    logic [35:0] leds;
    logic [6:0]  db_state, db_state2;
    logic [2:0]  db_appleX, db_appleY, db_headX, db_headY;
    logic [3:0]  db_size;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    sga #(.MOVE_PERIOD(MP), .MAX_SIZE(MS), .LFSR_SEED(6'h2D)) dut (
        .clock(clock), .restart(restart), .buttons(buttons), .start(start),
        .leds(leds), .db_state(db_state), .db_state2(db_state2),
        .db_appleX(db_appleX), .db_appleY(db_appleY),
        .db_headX(db_headX), .db_headY(db_headY), .db_size(db_size)
    );

    task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    endtask

    // ---------------- game model ----------------
    int m_phase, m_dir, m_pend, m_tick, m_lfsr, m_apple;
    int snake[$];          // front = head
    bit m_valid = 1'b0;

    function automatic int lfsr_next(input int v);
        return ((v << 1) & 63) | (((v >> 5) ^ (v >> 4)) & 1);
    endfunction

    function automatic bit on_snake(input int c, input int n);
        for (int i = 0; i < n; i++) if (snake[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic sample_buttons();
        for (int b = 0; b < 4; b++) begin
            if (buttons[b]) begin
                if (!(snake.size() > 1 && b == (m_dir + 2) % 4)) m_pend = b;
                return;
            end
        end
    endtask

    task automatic model_step();
        int cand, hx, hy, nx, ny, nc;
        bit eat;
        if (restart) begin
            m_phase = 0; snake.delete(); m_dir = 3; m_pend = 3;
            m_tick = 0; m_lfsr = 45; m_apple = 0; m_valid = 1'b1;
            return;
        end
        case (m_phase)
            0: if (start) m_phase = 1;
            1: begin
                snake.delete(); snake.push_back(14);
                m_dir = 3; m_pend = 3; m_tick = 0; m_phase = 2;
            end
            2: begin
                sample_buttons();
                cand = m_lfsr;
                m_lfsr = lfsr_next(m_lfsr);
                if (cand < 36 && !on_snake(cand, snake.size())) begin
                    m_apple = cand; m_phase = 3;
                end
            end
            3: begin
                sample_buttons();
                if (m_tick == MP - 1) begin m_tick = 0; m_phase = 4; end
                else m_tick++;
            end
            4: begin
                m_dir = m_pend;
                hx = snake[0] % 6; hy = snake[0] / 6;
                nx = hx + DX[m_dir]; ny = hy + DY[m_dir];
                if (nx < 0 || nx > 5 || ny < 0 || ny > 5) begin
                    m_phase = 14;
                end else begin
                    nc = ny * 6 + nx;
                    eat = (nc == m_apple);
                    if (on_snake(nc, eat ? snake.size() : snake.size() - 1)) begin
                        m_phase = 14;
                    end else begin
                        snake.push_front(nc);
                        if (!eat) void'(snake.pop_back());
                        if (eat) m_phase = (snake.size() == MS) ? 10 : 2;
                        else     m_phase = 3;
                    end
                end
            end
            10, 14: if (start) m_phase = 1;
            default: m_phase = 0;
        endcase
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // Every-cycle comparison of all outputs against the model
    initial forever begin
        logic [35:0] e_leds;
        int hc;
        @(negedge clock);
        if (m_valid) begin
            e_leds = '0;
            if (m_phase != 0) begin
                foreach (snake[k]) e_leds[snake[k]] = 1'b1;
                if (m_phase == 3 || m_phase == 4 || m_phase == 10 || m_phase == 14)
                    e_leds[m_apple] = 1'b1;
            end
            hc = (snake.size() > 0) ? snake[0] : 0;
            check("cycle_model",
                  {leds, db_state, db_state2, db_appleX, db_appleY, db_headX, db_headY, db_size},
                  {e_leds, SEG[m_phase], SEG[m_dir], 3'(m_apple % 6), 3'(m_apple / 6),
                   3'(hc % 6), 3'(hc / 6), 4'(snake.size())});
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic int head_cell();
        return int'(db_headY) * 6 + int'(db_headX);
    endfunction

    function automatic int apple_cell();
        return int'(db_appleY) * 6 + int'(db_appleX);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_head(input int x, input int y, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (db_headX == 3'(x) && db_headY == 3'(y)) break;
            @(negedge clock);
        end
        check(name, {db_headX, db_headY}, {3'(x), 3'(y)});
    endtask

    task automatic wait_state(input logic [6:0] s, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (db_state == s) break;
            @(negedge clock);
        end
        check(name, db_state, s);
    endtask

    task automatic wait_move(input int budget, input string name);
        int h0;
        h0 = head_cell();
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (head_cell() != h0) break;
        end
        check(name, head_cell() != h0, 1'b1);
    endtask

    initial begin
        int last, ap, hx0, a;
        last = 0; ap = 0;

        // Reset state
        @(negedge clock);
        check("rst_state", db_state, 7'h40);
        check("rst_size", db_size, 4'd0);
        check("rst_leds", leds, 36'd0);
        check("rst_head", {db_headX, db_headY}, 6'd0);
        check("rst_dir", db_state2, 7'h30);
        restart = 1'b0;
        @(negedge clock);

        // Game 1: no buttons, snake runs right into the wall
        pulse_start();
        check("init_state", db_state, 7'h79);
        @(negedge clock);
        check("place_state", db_state, 7'h24);
        check("place_size", db_size, 4'd1);
        check("place_head", {db_headX, db_headY}, {3'd2, 3'd2});
        check("place_leds", leds, 36'h0_0000_4000);
        wait_state(7'h30, 20, "enter_wait");
        a = apple_cell();
        check("apple_valid", (a != 14) && (db_appleX < 3'd6) && (db_appleY < 3'd6), 1'b1);
        check("apple_lit", $countones(leds), 2);
        repeat (8) @(negedge clock);
        check("move_after_period", db_state, 7'h19);
        check("move_head_unchanged", {db_headX, db_headY}, {3'd2, 3'd2});
        @(negedge clock);
        check("step1_head", {db_headX, db_headY}, {3'd3, 3'd2});
        wait_head(4, 2, 30, "step2_head");
        wait_head(5, 2, 30, "step3_head");
        wait_state(7'h06, 30, "wall_lost");
        check("lost_no_wrap", {db_headX, db_headY}, {3'd5, 3'd2});

        // Game 2: hold up
        buttons = 4'b0001;
        pulse_start();
        wait_head(2, 1, 40, "up_step1");
        check("up_dir", db_state2, 7'h40);
        wait_head(2, 0, 40, "up_step2");
        wait_state(7'h06, 40, "top_lost");
        buttons = 4'b0000;

        // Game 3: steer to the apple
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            if (db_size == 4'd2) break;
            last = head_cell();
            ap   = apple_cell();
            if (db_appleX < db_headX)      buttons = 4'b0010;
            else if (db_appleX > db_headX) buttons = 4'b1000;
            else if (db_appleY < db_headY) buttons = 4'b0001;
            else                           buttons = 4'b0100;
            @(negedge clock);
        end
        buttons = 4'b0000;
        check("eat_size", db_size, 4'd2);
        check("eat_head_on_apple", head_cell(), ap);
        check("eat_tail_kept", leds[last], 1'b1);
        check("eat_frame_count", $countones(leds), 2);
        wait_state(7'h30, 20, "replace_wait");
        a = apple_cell();
        check("new_apple_off_body", (a != head_cell()) && (a != last) && (db_appleX < 3'd6), 1'b1);
        check("new_apple_lit", $countones(leds), 3);

        // Turn right, then try to reverse
        buttons = 4'b1000;
        wait_move(40, "right_move");
        check("right_dir", db_state2, 7'h30);
        hx0 = int'(db_headX);
        buttons = 4'b0010;
        wait_move(40, "reverse_move");
        check("reverse_ignored_dir", db_state2, 7'h30);
        check("reverse_ignored_x", db_headX, 3'(hx0 + 1));
        buttons = 4'b0000;

        // start is ignored mid-game, restart wins
        wait_state(7'h30, 20, "wait_before_start");
        pulse_start();
        check("start_ignored", db_state != 7'h79, 1'b1);
        wait_state(7'h30, 20, "wait_before_restart");
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        check("restart_state", db_state, 7'h40);
        check("restart_leds", leds, 36'd0);
        check("restart_size", db_size, 4'd0);
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
